cache_line_ram: RTL and testbench
=================================

# cache_line_ram

Parametrised single-port cache-line RAM with a built-in initialisation sequencer and a valid/ready request port. After reset, or on request, it fills every line with a deterministic pattern in hardware, one line per cycle. It then serves full-line reads and word-masked writes. It sits behind the cache controller as the line store and gives the controller known contents without simulation-only initialisation.

## Interface
Parameters:
- CACHE_LINE, 128, line width in bits; must be an integer multiple of DATA_WIDTH
- CACHE_DEPTH, 32, number of lines; must be ≥ 2 and need not be a power of two
- DATA_WIDTH, 32, word width in bits
- INIT_MODE, 0, fill pattern: 0 = word index, 1 = all zeros
- ADDR_WIDTH (derived), $clog2(CACHE_DEPTH)
- N_DATA_LINE (derived), CACHE_LINE/DATA_WIDTH

Ports:
- clk_i, in, 1, single clock, rising edge
- rstn_i, in, 1, reset, asynchronous, active-low
- init_req_i, in, 1, request a full re-initialisation
- init_busy_o, out, 1, high while the fill sequence runs
- req_valid_i, in, 1, request valid
- req_ready_o, out, 1, block can accept a request
- req_we_i, in, 1, 1 = write, 0 = read
- req_addr_i, in, ADDR_WIDTH, line address
- req_wdata_i, in, CACHE_LINE, write data
- req_wmask_i, in, N_DATA_LINE, per-word write enable; bit j covers bits [j*DATA_WIDTH +: DATA_WIDTH]
- rsp_valid_o, out, 1, read data valid pulse
- rsp_data_o, out, CACHE_LINE, registered read data

## Operation
- The FSM has two states: S_INIT and S_READY.
- Reset state:
  - S_INIT, with the fill counter at 0.
  - init_busy_o=1, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0.
- S_INIT behaviour:
  - Each cycle writes line fill_cnt and increments the counter.
  - After writing line CACHE_DEPTH-1, the FSM goes to S_READY.
- Fill pattern:
  - INIT_MODE 0: word j of line i = (i*N_DATA_LINE + j), truncated to DATA_WIDTH.
  - INIT_MODE 1: every word is 0.
- req_ready_o and init_busy_o are registered decodes of the state: ready = (S_READY), busy = (S_INIT).
- A request is accepted when req_valid_i && req_ready_o.
- Accepted write:
  - Only words whose req_wmask_i bit is 1 are updated.
  - A mask of all zeros is a no-op.
- Accepted read: rsp_data_o loads the addressed line and rsp_valid_o is 1 in the next cycle.
  - There is no response backpressure.
  - rsp_data_o holds its value until the next read response.
- Writes produce no response.
- Out-of-range address (req_addr_i ≥ CACHE_DEPTH):
  - A write is dropped.
  - A read returns all zeros, with the normal rsp_valid_o pulse.
- init_req_i in S_READY:
  - The FSM enters S_INIT on the next edge with fill_cnt=0.
  - A request accepted in that same cycle is still performed, and its read response is still delivered.
- init_req_i during S_INIT is ignored; the fill is not restarted.
- Reset asserted mid-fill or mid-request:
  - All state and outputs return to reset values immediately.
  - The fill restarts from line 0 after release.
  - Memory contents are not reset; the fill overwrites them.

## Timing
- Reset release to ready: the first rising edge after rstn_i=1 writes line 0. Edge CACHE_DEPTH writes the last line, and req_ready_o=1 after that edge.
- With defaults, ready rises 32 cycles after release.
- Read latency: 1 cycle from the accepting edge to rsp_valid_o/rsp_data_o.
- Throughput: one request per cycle in S_READY.
- Write-then-read on consecutive cycles to the same line returns the newly written data.
- Re-init: init_req_i sampled at edge t gives req_ready_o=0 after t. req_ready_o=1 again after edge t+CACHE_DEPTH.
- rsp_valid_o is a single-cycle pulse per accepted read; back-to-back reads give back-to-back pulses.

## Test plan
- Reset, then wait for ready; read lines 0, 1 and 31 → rsp_data_o = {3,2,1,0}, {7,6,5,4} and {127,126,125,124} (word 3..0). Ready asserts exactly 32 cycles after release.
- Write line 5 with wdata={D,C,B,A}, mask=4'b0101, then read line 5 on the next cycle → {23,C,21,A}. Also check that 1-cycle latency is met.
- Four back-to-back reads of lines 0-3 → four consecutive rsp_valid_o pulses carrying data in order.
- With CACHE_DEPTH=20 and INIT_MODE=1: write to address 25, then read address 25 → rsp_data_o=0. Also check that line 19 still reads 0 and was not corrupted.
- Assert init_req_i together with a write to line 2 → the write is performed, then ready drops for 32 cycles. Line 2 then reads the fill pattern {11,10,9,8}.
- Assert rstn_i low at fill_cnt=10, then release → outputs return to reset values at once, and ready returns 32 cycles after release.

Source files
------------

// File: rtl/cache_line_ram.sv
// Single-port cache-line store that self-fills with a known pattern after reset or on request.
// Latency: read data and rsp_valid_o are registered, one cycle after the accepting edge; writes produce no response.
// Backpressure: req_ready_o is low for the whole fill; there is no response backpressure, so reads must be consumed on the pulse.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   init_req_i, init_busy_o  re-initialisation request / fill in progress
//   req_valid_i/req_ready_o  request handshake; req_we_i, req_addr_i, req_wdata_i, req_wmask_i qualify it
//   rsp_valid_o, rsp_data_o  read response pulse and held read data
module cache_line_ram #(
    parameter  int CACHE_LINE  = 128,
    parameter  int CACHE_DEPTH = 32,
    parameter  int DATA_WIDTH  = 32,
    parameter  int INIT_MODE   = 0,
    localparam int ADDR_WIDTH  = $clog2(CACHE_DEPTH),
    localparam int N_DATA_LINE = CACHE_LINE / DATA_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   init_req_i,
    output logic                   init_busy_o,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [CACHE_LINE-1:0]  req_wdata_i,
    input  logic [N_DATA_LINE-1:0] req_wmask_i,
    output logic                   rsp_valid_o,
    output logic [CACHE_LINE-1:0]  rsp_data_o
);

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_LINE = ADDR_WIDTH'(CACHE_DEPTH - 1);
    // One extra bit so the bound compare works when CACHE_DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(CACHE_DEPTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
    logic [CACHE_LINE-1:0]   mem [CACHE_DEPTH];
    logic [CACHE_LINE-1:0]   fill_line;
    logic                    req_acc;
    logic                    addr_ok;
    logic                    wr_acc;
    logic                    rd_acc;

    // req_ready_o is a registered copy of (state_q == S_READY), so it can
    // gate acceptance directly without looking at the state register.
    assign req_acc = req_valid_i && req_ready_o;
    assign addr_ok = ({1'b0, req_addr_i} < DEPTH_EXT);
    assign wr_acc  = req_acc && req_we_i && addr_ok;
    assign rd_acc  = req_acc && !req_we_i;

    // Fill pattern for the line currently addressed by the fill counter.
    always_comb begin
        fill_line = '0;
        if (INIT_MODE == 0) begin
            for (int j = 0; j < N_DATA_LINE; j++) begin
                fill_line[j*DATA_WIDTH +: DATA_WIDTH] =
                    DATA_WIDTH'(int'(fill_cnt_q) * N_DATA_LINE + j);
            end
        end
    end

    // Next-state logic. init_req_i only matters in S_READY; a fill in
    // progress is never restarted by it.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            S_INIT: begin
                if (fill_cnt_q == LAST_LINE) begin
                    state_d    = S_READY;
                    fill_cnt_d = '0;
                end else begin
                    fill_cnt_d = fill_cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_READY: begin
                if (init_req_i) begin
                    state_d    = S_INIT;
                    fill_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_INIT;
                fill_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_INIT;
            fill_cnt_q  <= '0;
            init_busy_o <= 1'b1;
            req_ready_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            init_busy_o <= (state_d == S_INIT);
            req_ready_o <= (state_d == S_READY);
        end
    end

    // Line storage has no reset; the fill sequencer defines its contents.
    // A request accepted in the cycle init_req_i is seen still lands here,
    // because the state only flips to S_INIT on that same edge.
    always_ff @(posedge clk_i) begin
        if (state_q == S_INIT) begin
            mem[fill_cnt_q] <= fill_line;
        end else if (wr_acc) begin
            for (int j = 0; j < N_DATA_LINE; j++) begin
                if (req_wmask_i[j]) begin
                    mem[req_addr_i][j*DATA_WIDTH +: DATA_WIDTH] <=
                        req_wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read response: out-of-range reads still pulse valid but return zeros.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= rd_acc;
            if (rd_acc) begin
                rsp_data_o <= addr_ok ? mem[req_addr_i] : '0;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_ram.sv
module tb_cache_line_ram;

    localparam int CL = 128;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int D  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    // default instance
    logic            init_req, busy, ready, vld, we, rsp_vld;
    logic [4:0]      addr;
    logic [CL-1:0]   wdata, rsp_dat;
    logic [N-1:0]    wmask;
    // CACHE_DEPTH=20, INIT_MODE=1 instance
    logic            init_req2, busy2, ready2, vld2, we2, rsp_vld2;
    logic [4:0]      addr2;
    logic [CL-1:0]   wdata2, rsp_dat2;
    logic [N-1:0]    wmask2;

    cache_line_ram dut (
        .clk_i(clk), .rstn_i(rstn),
        .init_req_i(init_req), .init_busy_o(busy),
        .req_valid_i(vld), .req_ready_o(ready), .req_we_i(we),
        .req_addr_i(addr), .req_wdata_i(wdata), .req_wmask_i(wmask),
        .rsp_valid_o(rsp_vld), .rsp_data_o(rsp_dat)
    );

    cache_line_ram #(.CACHE_DEPTH(20), .INIT_MODE(1)) dut2 (
        .clk_i(clk), .rstn_i(rstn),
        .init_req_i(init_req2), .init_busy_o(busy2),
        .req_valid_i(vld2), .req_ready_o(ready2), .req_we_i(we2),
        .req_addr_i(addr2), .req_wdata_i(wdata2), .req_wmask_i(wmask2),
        .rsp_valid_o(rsp_vld2), .rsp_data_o(rsp_dat2)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [CL-1:0] model [D];
    logic [CL-1:0] last_rd;

    task automatic chk(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word j of line i holds i*N + j after a word-index fill.
    function automatic logic [CL-1:0] pat(input int i);
        logic [CL-1:0] l;
        for (int j = 0; j < N; j++) l[j*DW +: DW] = 32'(i * N + j);
        return l;
    endfunction

    task automatic refill();
        for (int i = 0; i < D; i++) model[i] = pat(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a);
        vld = 1'b1; we = 1'b0; addr = 5'(a);
        tick();
        vld = 1'b0;
        last_rd = model[a];
        chk("rd_vld", CL'(rsp_vld), CL'(1));
        chk("rd_dat", rsp_dat, model[a]);
    endtask

    task automatic rd2(input int a);
        vld2 = 1'b1; we2 = 1'b0; addr2 = 5'(a);
        tick();
        vld2 = 1'b0;
        chk("oor_vld", CL'(rsp_vld2), CL'(1));
        chk("oor_dat", rsp_dat2, '0);
    endtask

    task automatic wait_ready(input string tag, input int exp_k);
        int k;
        k = 0;
        while (!ready && k < 100) begin
            // A request in mid-fill must be ignored.
            init_req = (k == 10);
            tick();
            k++;
        end
        init_req = 1'b0;
        chk(tag, CL'(k), CL'(exp_k));
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] wa, wb, wc, wd;
        int k, k2;

        rstn = 1'b0;
        init_req = 0; vld = 0; we = 0; addr = '0; wdata = '0; wmask = '0;
        init_req2 = 0; vld2 = 0; we2 = 0; addr2 = '0; wdata2 = '0; wmask2 = '0;
        tick(); tick();

        chk("rst_busy",   CL'(busy),    CL'(1));
        chk("rst_ready",  CL'(ready),   CL'(0));
        chk("rst_rspvld", CL'(rsp_vld), CL'(0));
        chk("rst_rspdat", rsp_dat,      '0);
        chk("rst_ready2", CL'(ready2),  CL'(0));

        // Release: ready after edge 32 (depth 32) and edge 20 (depth 20).
        rstn = 1'b1;
        k = 0; k2 = 0;
        while (!ready && k < 100) begin
            tick();
            k++;
            if (ready2 && k2 == 0) k2 = k;
        end
        chk("ready_lat",  CL'(k),    CL'(32));
        chk("ready2_lat", CL'(k2),   CL'(20));
        chk("busy_low",   CL'(busy), CL'(0));
        refill();

        rd(0);  chk("line0",  rsp_dat, {32'd3, 32'd2, 32'd1, 32'd0});
        rd(1);  chk("line1",  rsp_dat, {32'd7, 32'd6, 32'd5, 32'd4});
        rd(31); chk("line31", rsp_dat, {32'd127, 32'd126, 32'd125, 32'd124});

        // Masked write to line 5, then read it on the next cycle.
        wa = $urandom; wb = $urandom; wc = $urandom; wd = $urandom;
        vld = 1; we = 1; addr = 5'd5; wdata = {wd, wc, wb, wa}; wmask = 4'b0101;
        tick();
        vld = 0;
        chk("wr_no_rsp", CL'(rsp_vld), CL'(0));
        chk("wr_hold",   rsp_dat, last_rd);
        model[5][0*DW +: DW] = wa;
        model[5][2*DW +: DW] = wc;
        rd(5);
        chk("line5_mask", rsp_dat, {32'd23, wc, 32'd21, wa});

        // Back-to-back reads give back-to-back pulses.
        for (int i = 0; i < 4; i++) begin
            vld = 1; we = 0; addr = 5'(i);
            tick();
            chk("b2b_vld", CL'(rsp_vld), CL'(1));
            chk("b2b_dat", rsp_dat, model[i]);
        end
        last_rd = model[3];
        vld = 0;
        tick();
        chk("b2b_end", CL'(rsp_vld), CL'(0));

        // Out-of-range accesses on the depth-20 zero-filled instance.
        vld2 = 1; we2 = 1; addr2 = 5'd25; wdata2 = '1; wmask2 = '1;
        tick();
        vld2 = 0;
        rd2(25);
        rd2(19);
        rd2(5);

        // Random traffic against the line model.
        for (int it = 0; it < 300; it++) begin
            logic v, w;
            int a;
            logic [N-1:0] m;
            logic [CL-1:0] d;
            v = 1'($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            a = $urandom_range(0, D - 1);
            m = 4'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            vld = v; we = w; addr = 5'(a); wmask = m; wdata = d;
            if (v && w) begin
                for (int j = 0; j < N; j++)
                    if (m[j]) model[a][j*DW +: DW] = d[j*DW +: DW];
            end else if (v) begin
                last_rd = model[a];
            end
            tick();
            chk("rnd_vld", CL'(rsp_vld), CL'(v && !w));
            chk("rnd_dat", rsp_dat, last_rd);
        end
        vld = 0;

        // Read accepted together with init_req still responds.
        init_req = 1; vld = 1; we = 0; addr = 5'd7;
        tick();
        init_req = 0; vld = 0;
        chk("init_rd_vld", CL'(rsp_vld), CL'(1));
        chk("init_rd_dat", rsp_dat, model[7]);
        chk("init_rdy_lo", CL'(ready), CL'(0));
        wait_ready("reinit_lat_a", 32);
        refill();

        // Write accepted with init_req, then the fill overwrites line 2.
        init_req = 1; vld = 1; we = 1; addr = 5'd2; wmask = '1;
        wdata = {$urandom, $urandom, $urandom, $urandom};
        tick();
        init_req = 0; vld = 0;
        chk("init_wr_rdy", CL'(ready), CL'(0));
        chk("init_wr_bsy", CL'(busy),  CL'(1));
        wait_ready("reinit_lat_b", 32);
        rd(2);
        chk("line2_refill", rsp_dat, {32'd11, 32'd10, 32'd9, 32'd8});

        // Reset in mid-fill (fill_cnt = 10) returns outputs at once.
        init_req = 1;
        tick();
        init_req = 0;
        for (int i = 0; i < 10; i++) tick();
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy",   CL'(busy),    CL'(1));
        chk("mid_rst_ready",  CL'(ready),   CL'(0));
        chk("mid_rst_rspvld", CL'(rsp_vld), CL'(0));
        chk("mid_rst_rspdat", rsp_dat,      '0);
        tick(); tick();
        rstn = 1'b1;
        k = 0;
        while (!ready && k < 100) begin
            tick();
            k++;
        end
        chk("rst_ready_lat", CL'(k), CL'(32));
        rd(0);
        rd(31);
        rd(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
